pram_queue: RTL and testbench
=============================

Name: pram_queue

Overview:
- Queue behind the PRAM address of the memory controller.
- CPU stores to PRAM push 16-bit words into the write port; a downstream consumer pops them through a valid/ready read port.
- The queue returns `full`, which the memory controller presents to the CPU on PRAM loads (bit 0) so software can poll before writing.
- First-word-fall-through FIFO with overflow detection and occupancy count.

Parameters:
- WIDTH, 16, data word width; matches the PRAM write data.
- ADDR_W, 4, pointer width. DEPTH = 2**ADDR_W = 16 entries. Only power-of-two depths are supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_data  in  WIDTH  word to enqueue (PRAM_Out from the memory controller).
- wr_en  in  1  enqueue request (PRAM_Wr_En); one word per cycle while high.
- full  out  1  queue holds DEPTH words.
- rd_data  out  WIDTH  head-of-queue word; valid only while rd_valid = 1.
- rd_valid  out  1  queue non-empty.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- overflow_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0.
  - full = 0, rd_valid = 0.
  - Storage array contents are not reset; rd_data is don't-care while rd_valid = 0.
  - Reset mid-transfer discards all queued words; no partial state survives.
- Derived flags:
  - full = (count == DEPTH), rd_valid = (count != 0). Both come combinationally from the registered count, so they never depend on same-cycle inputs.
- push = wr_en & ~full. On push: mem[wr_ptr] <= wr_data, and wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- pop = rd_valid & rd_ready. On pop: rd_ptr increments modulo DEPTH.
- rd_data = mem[rd_ptr], combinational read (fall-through). The word at the head is presented with no pop request needed.
- Count update:
  - push and no pop: +1.
  - pop and no push: -1.
  - both, or neither: unchanged.
- Latency: a word pushed in cycle N appears on rd_data with rd_valid = 1 in cycle N+1 if the queue was empty. Otherwise it appears behind the older words, in order.
- Throughput: one push and one pop per cycle simultaneously, sustained indefinitely at any occupancy 1..DEPTH-1.
- Boundary conditions:
  - Full, wr_en = 1, rd_ready = 0: write dropped, overflow <= 1, memory and pointers unchanged.
  - Full, wr_en = 1, rd_ready = 1: pop occurs, write still dropped (full is registered), overflow <= 1, count -> DEPTH-1. Software must poll full before each store.
  - Empty, rd_ready = 1, wr_en = 0: no pop, pointers unchanged, count stays 0.
  - Empty, wr_en = 1, rd_ready = 1: push only. rd_valid is 0 this cycle, so no same-cycle bypass; the word appears next cycle.
  - Pointer wrap: after DEPTH pushes and DEPTH pops, both pointers return to 0 with no data corruption.
- overflow:
  - Set by any dropped write.
  - Cleared by overflow_clr.
  - If set and clear coincide in one cycle, set wins.
- No other state; no state machine beyond the pointers and count registers.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high with wr_en = rd_ready = 0 -> count = 0, full = 0, rd_valid = 0, overflow = 0.
- Single word: push 16'hBEEF at cycle N with rd_ready = 0 -> cycle N+1 rd_valid = 1, rd_data = BEEF, count = 1. Then rd_ready = 1 for one cycle -> count = 0, rd_valid = 0.
- Fill to full: push 0x0001..0x0010 with rd_ready = 0 -> after 16th push full = 1, count = 16. 17th push of 0xFFFF -> dropped, overflow = 1. Drain -> reads 0x0001..0x0010 in order, never 0xFFFF.
- Streaming and wrap: wr_en = rd_ready = 1 continuously for 40 cycles with an incrementing pattern, after one preload word -> count stays 1, output sequence is exact and gap-free across pointer wrap.
- Full with simultaneous read/write: at count = 16, wr_en = rd_ready = 1 -> count = 15, overflow = 1, the popped word is the oldest, and the written word is absent from later drain. overflow_clr with no new overflow -> overflow = 0. overflow_clr coinciding with a dropped write -> overflow stays 1.
- Async reset mid-stream: at count = 7, assert rst_n low between clock edges -> outputs clear immediately without a clock edge. After release, the first new push 16'h1234 is the first word read.

Source files
------------

// File: rtl/pram_queue.sv
// ---------------------------------------------------------------------------
// pram_queue
//   First-word-fall-through FIFO sitting behind the PRAM address of the memory
//   controller. CPU stores push words in; a downstream consumer pops them
//   through a valid/ready port. Writes attempted while full are dropped and
//   latched in a sticky overflow flag.
//
// Ports
//   clk           system clock, rising-edge
//   rst_n         asynchronous active-low reset
//   wr_data       word to enqueue
//   wr_en         enqueue request, one word per cycle while high
//   full          queue holds DEPTH words (from registered count)
//   rd_data       head-of-queue word, meaningful only while rd_valid = 1
//   rd_valid      queue non-empty (from registered count)
//   rd_ready      consumer accepts rd_data this cycle
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was attempted while full
//   overflow_clr  synchronous clear of overflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module pram_queue #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int DEPTH = 1 << ADDR_W;
  // DEPTH expressed at count width: MSB set, all lower bits clear.
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push_s;
  logic              pop_s;

  // Flags come only from the registered count, never from same-cycle inputs.
  assign full     = (count_q == DEPTH_C);
  assign rd_valid = (count_q != {(ADDR_W+1){1'b0}});
  assign count    = count_q;
  assign overflow = overflow_q;

  // Fall-through read: the head word is presented without a pop request.
  assign rd_data  = mem_q[rd_ptr_q];

  assign push_s = wr_en & ~full;
  assign pop_s  = rd_valid & rd_ready;

  // Next-state computation for pointers, occupancy and the sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // A dropped write outranks a coincident clear so no overflow is lost.
    if (wr_en & full) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control registers: cleared asynchronously so a reset discards all words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      count_q    <= {(ADDR_W+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array: not reset, contents only observable through rd_valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_pram_queue.sv
module tb_pram_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  count;
  logic        overflow;
  logic        overflow_clr;

  int checks;
  int errors;

  pram_queue #(.WIDTH(16), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_ready = 1'b0; overflow_clr = 1'b0; wr_data = 16'h0000;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_single();
    wr_data = 16'hBEEF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h exp beef", rd_data); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d exp 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b exp 0", rd_valid); end
    // Empty with rd_ready high: nothing pops, count stays 0.
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL empty_pop_count got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_data = 16'(i); wr_en = 1'b1;
      step();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count); end
    wr_data = 16'hFFFF;
    step();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_drop_count got %0d exp 16", count); end
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
        errors++; $display("FAIL fill_drain_%0d got %h valid %b exp %h", i, rd_data, rd_valid, 16'(i));
      end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL fill_drain_count got %0d exp 0", count); end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_clr got %b exp 0", overflow); end
  endtask

  task automatic test_back_to_back();
    wr_data = 16'h1000; wr_en = 1'b1;
    step();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(16'h1000 + i)) begin
        errors++; $display("FAIL stream_%0d got %h valid %b exp %h", i, rd_data, rd_valid, 16'(16'h1000 + i));
      end
      wr_data = 16'(16'h1001 + i);
      step();
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL stream_count_%0d got %0d exp 1", i, count); end
    end
    wr_en = 1'b0;
    checks++; if (rd_data !== 16'h1028) begin errors++; $display("FAIL stream_last got %h exp 1028", rd_data); end
    step();
    rd_ready = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", count); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) begin
      wr_data = 16'(16'h2000 + i); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full got %b exp 1", full); end
    checks++; if (rd_data !== 16'h2000) begin errors++; $display("FAIL frw_head got %h exp 2000", rd_data); end
    wr_data = 16'hDEAD; wr_en = 1'b1; rd_ready = 1'b1;
    step();
    wr_en = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL frw_count got %0d exp 15", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL frw_overflow got %b exp 1", overflow); end
    checks++; if (rd_data !== 16'h2001) begin errors++; $display("FAIL frw_next_head got %h exp 2001", rd_data); end
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_clr got %b exp 0", overflow); end
    wr_data = 16'h2010; wr_en = 1'b1;
    step();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL frw_refill got %0d exp 16", count); end
    wr_data = 16'hBAD0; overflow_clr = 1'b1;
    step();
    wr_en = 1'b0; overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL frw_set_wins got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL frw_set_count got %0d exp 16", count); end
    rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(16'h2000 + i)) begin
        errors++; $display("FAIL frw_drain_%0d got %h valid %b exp %h", i, rd_data, rd_valid, 16'(16'h2000 + i));
      end
      step();
    end
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL frw_empty got %b exp 0", rd_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      wr_data = 16'(16'h3000 + i); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    checks++; if (count !== 5'd7) begin errors++; $display("FAIL ar_pre_count got %0d exp 7", count); end
    // overflow is still set from the previous scenario; reset must clear it.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", count); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", rd_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL ar_full got %b exp 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ar_overflow got %b exp 0", overflow); end
    #2 rst_n = 1'b1;
    wr_data = 16'h1234; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      errors++; $display("FAIL ar_first got %h valid %b exp 1234", rd_data, rd_valid);
    end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL ar_post_count got %0d exp 1", count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_full_rw();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
